// File: rtl/uart_pkg.sv
// Shared types and line levels for the UART receive path.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_t;

    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;

endpackage

// File: rtl/uart_bit_timer.sv
// Cycle counter within one serial bit; flags the mid-bit and end-of-bit cycles.
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic half_tick,
    output logic full_tick
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] ONE     = {{(CW-1){1'b0}}, 1'b1};

    logic [CW-1:0] count_r;

    // Free-running bit counter, wraps at end of bit or on clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_r <= '0;
        end else if (clear || (count_r == FULL_M1)) begin
            count_r <= '0;
        end else begin
            count_r <= count_r + ONE;
        end
    end

    assign half_tick = (count_r == HALF_M1);
    assign full_tick = (count_r == FULL_M1);

endmodule

// File: rtl/uart_rx.sv
// 8N1-style serial receiver with mid-bit sampling, valid/ready output,
// framing-error and overrun pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_WIDTH   = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  rx,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  valid,
    input  logic                  ready,
    output logic                  framing_err,
    output logic                  overrun
);

    localparam int BCW = $clog2(DATA_WIDTH + 1);
    localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_WIDTH - 1);
    localparam logic [BCW-1:0] BIT_ONE  = {{(BCW-1){1'b0}}, 1'b1};

    rx_state_t             state_r;
    logic [BCW-1:0]        bit_cnt_r;
    logic [DATA_WIDTH-1:0] shift_r;
    logic                  timer_clear_s;
    logic                  half_tick_s;
    logic                  full_tick_s;

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clock    (clock),
        .reset    (reset),
        .clear    (timer_clear_s),
        .half_tick(half_tick_s),
        .full_tick(full_tick_s)
    );

    // Timer is held at zero while waiting and cleared on every state change.
    always_comb begin
        timer_clear_s = 1'b0;
        case (state_r)
            IDLE:    timer_clear_s = 1'b1;
            START:   timer_clear_s = half_tick_s;
            DATA:    timer_clear_s = full_tick_s && (bit_cnt_r == LAST_BIT);
            STOP:    timer_clear_s = full_tick_s;
            BREAK:   timer_clear_s = 1'b1;
            default: timer_clear_s = 1'b1;
        endcase
    end

    // Frame FSM, shift register and registered consumer-side outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            bit_cnt_r   <= '0;
            shift_r     <= '0;
            data        <= '0;
            valid       <= 1'b0;
            framing_err <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            framing_err <= 1'b0;
            overrun     <= 1'b0;
            // A load in STOP below overrides this consumption.
            if (valid && ready) begin
                valid <= 1'b0;
            end
            case (state_r)
                IDLE: begin
                    if (rx == LINE_START) begin
                        state_r <= START;
                    end
                end
                START: begin
                    if (half_tick_s) begin
                        if (rx == LINE_START) begin
                            state_r   <= DATA;
                            bit_cnt_r <= '0;
                        end else begin
                            state_r <= IDLE;
                        end
                    end
                end
                DATA: begin
                    if (full_tick_s) begin
                        shift_r <= {rx, shift_r[DATA_WIDTH-1:1]};
                        if (bit_cnt_r == LAST_BIT) begin
                            state_r   <= STOP;
                            bit_cnt_r <= '0;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + BIT_ONE;
                        end
                    end
                end
                STOP: begin
                    if (full_tick_s) begin
                        if (rx == LINE_IDLE) begin
                            if (!valid || ready) begin
                                data  <= shift_r;
                                valid <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                            state_r <= IDLE;
                        end else begin
                            framing_err <= 1'b1;
                            state_r     <= BREAK;
                        end
                    end
                end
                BREAK: begin
                    // Hold off until the line returns idle so a stuck-low line cannot re-trigger.
                    if (rx == LINE_IDLE) begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed plus randomized bench for uart_rx; a transaction-level model predicts
// valid/data/error pulses every cycle from the line waveform the bench drives.
module tb_uart_rx;

    localparam int CPB  = 16;
    localparam int HALF = CPB / 2;
    localparam int W    = 8;

    logic         clock = 1'b0;
    logic         reset;
    logic         rx;
    logic         ready;
    logic [W-1:0] data;
    logic         valid;
    logic         framing_err;
    logic         overrun;

    always #5 clock = ~clock;

    uart_rx #(
        .CLKS_PER_BIT(CPB),
        .DATA_WIDTH  (W)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .rx         (rx),
        .data       (data),
        .valid      (valid),
        .ready      (ready),
        .framing_err(framing_err),
        .overrun    (overrun)
    );

    int           n_assert = 0;
    int           n_fail   = 0;
    logic         m_valid;
    logic [W-1:0] m_data;
    logic         e_ferr;
    logic         e_ovr;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("valid",       {7'd0, valid},       {7'd0, m_valid});
        chk("data",        data,                m_data);
        chk("framing_err", {7'd0, framing_err}, {7'd0, e_ferr});
        chk("overrun",     {7'd0, overrun},     {7'd0, e_ovr});
    endtask

    // One clock edge: predict its effect, let it happen, then compare.
    task automatic step(input logic deliver, input logic [W-1:0] w, input logic ferr);
        logic acc;
        acc    = m_valid && ready;
        e_ferr = ferr;
        e_ovr  = 1'b0;
        if (deliver) begin
            if (!m_valid || acc) begin
                m_data  = w;
                m_valid = 1'b1;
            end else begin
                e_ovr = 1'b1;
            end
        end else if (acc) begin
            m_valid = 1'b0;
        end
        @(posedge clock);
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) step(1'b0, 8'h00, 1'b0);
    endtask

    task automatic drive_bit(input logic lvl, input logic rand_rdy);
        rx = lvl;
        if (rand_rdy) ready = 1'($urandom_range(0, 1));
        repeat (CPB) step(1'b0, 8'h00, 1'b0);
    endtask

    // Full line-side frame; the outcome lands on the mid-point edge of the stop bit.
    task automatic send_frame(input logic [W-1:0] d, input logic stop_bit,
                              input logic rand_rdy, input int rdy_at_evt);
        drive_bit(1'b0, rand_rdy);
        for (int i = 0; i < W; i++) drive_bit(d[i], rand_rdy);
        rx = stop_bit;
        repeat (HALF) step(1'b0, 8'h00, 1'b0);
        if (rdy_at_evt >= 0) ready = rdy_at_evt[0];
        step(stop_bit, d, !stop_bit);
        repeat (CPB - HALF - 1) step(1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        logic [W-1:0] rd;
        logic         rs;
        reset   = 1'b1;
        rx      = 1'b1;
        ready   = 1'b0;
        m_valid = 1'b0;
        m_data  = 8'h00;
        e_ferr  = 1'b0;
        e_ovr   = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check_outputs();
        reset = 1'b0;
        idle(4);

        // Single frame consumed immediately.
        ready = 1'b1;
        send_frame(8'hA5, 1'b1, 1'b0, -1);
        idle(4);

        // Back-to-back frames with no consumer: second one overruns.
        ready = 1'b0;
        send_frame(8'h3C, 1'b1, 1'b0, -1);
        send_frame(8'hC3, 1'b1, 1'b0, -1);
        idle(4);
        ready = 1'b1;
        idle(3);

        // Framing error, held-low line, then recovery.
        send_frame(8'h55, 1'b0, 1'b0, -1);
        rx = 1'b0;
        repeat (100) step(1'b0, 8'h00, 1'b0);
        idle(5);
        send_frame(8'h0F, 1'b1, 1'b0, -1);
        idle(4);

        // Short glitch rejected, then a normal frame left unconsumed.
        ready = 1'b0;
        rx = 1'b0;
        repeat (3) step(1'b0, 8'h00, 1'b0);
        idle(8);
        send_frame(8'h81, 1'b1, 1'b0, -1);
        idle(4);

        // Asynchronous reset in the middle of data bit 4 of 0xF3.
        rd = 8'hF3;
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(rd[i], 1'b0);
        rx = rd[4];
        repeat (5) step(1'b0, 8'h00, 1'b0);
        reset = 1'b1;
        #1;
        m_valid = 1'b0;
        m_data  = 8'h00;
        e_ferr  = 1'b0;
        e_ovr   = 1'b0;
        check_outputs();
        repeat (3) step(1'b0, 8'h00, 1'b0);
        reset = 1'b0;
        repeat (CPB - 8) step(1'b0, 8'h00, 1'b0);
        for (int i = 5; i < W; i++) drive_bit(rd[i], 1'b0);
        idle(CPB + 4);
        send_frame(8'h7E, 1'b1, 1'b0, -1);
        idle(2);
        ready = 1'b1;
        idle(2);

        // New word lands on the same edge the old one is consumed.
        ready = 1'b0;
        send_frame(8'h11, 1'b1, 1'b0, -1);
        send_frame(8'h22, 1'b1, 1'b0, 1);
        idle(4);

        // Randomized frames, stop-bit errors, gaps and consumer readiness.
        for (int f = 0; f < 16; f++) begin
            rd = 8'($urandom);
            rs = ($urandom_range(0, 5) != 0);
            send_frame(rd, rs, 1'b1, -1);
            if (!rs) idle(2 + $urandom_range(0, 3));
            else     idle($urandom_range(0, 4));
        end
        ready = 1'b1;
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
